// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses UART RX bytes into register-file write/read frames
// and returns read data through the UART TX parallel input.
//   write frame: WR_CMD, addr, data  -> one rf_wr_en pulse
//   read  frame: RD_CMD, addr        -> rf_rd_en pulse, then tx_valid with read byte
// Optional macro UART_CMD_TIMEOUT_EN: aborts a frame when no byte arrives for
// TIMEOUT_CYC cycles in WR_ADDR/WR_DATA/RD_ADDR.
module uart_cmd_ctrl #(
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  WR_CMD      = 8'hAA,
  parameter logic [7:0]  RD_CMD      = 8'hBB,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_par_err,
  input  logic              rx_stp_err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [7:0]        rf_wr_data,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  input  logic [7:0]        rf_rd_data,
  input  logic              rf_rd_valid,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, TX_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q, rdata_q, tx_data_q;
  logic              seen_busy_q, seen_busy_d;
  logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic              tx_valid_q, tx_valid_d, ferr_q, ferr_d;
  logic              addr_ld, wdata_ld, rdata_ld;

  logic good, bad, tmo, in_frame;
  assign good     = rx_valid & ~rx_par_err & ~rx_stp_err;
  assign bad      = rx_valid & (rx_par_err | rx_stp_err);
  assign in_frame = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Idle-cycle count inside a frame; any byte or state change restarts it.
  always_comb begin
    cnt_d = '0;
    if (in_frame && !rx_valid && !tmo) cnt_d = cnt_q + 1'b1;
  end

  assign tmo = in_frame && !rx_valid && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (good && rx_data == WR_CMD)      state_d = WR_ADDR;
        else if (good && rx_data == RD_CMD) state_d = RD_ADDR;
      end
      WR_ADDR: begin
        if (bad || tmo) state_d = IDLE;
        else if (good)  state_d = WR_DATA;
      end
      WR_DATA: if (rx_valid || tmo) state_d = IDLE;
      RD_ADDR: begin
        if (bad || tmo) state_d = IDLE;
        else if (good)  state_d = RD_WAIT;
      end
      // With TX free, skip TX_SEND so tx_valid follows rf_rd_valid by one cycle.
      RD_WAIT: if (rf_rd_valid) state_d = tx_busy ? TX_SEND : TX_WAIT;
      TX_SEND: if (!tx_busy) state_d = TX_WAIT;
      TX_WAIT: if (seen_busy_q && !tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath-control logic; strobes are registered one cycle later.
  always_comb begin
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_valid_d  = 1'b0;
    ferr_d      = tmo;
    addr_ld     = 1'b0;
    wdata_ld    = 1'b0;
    rdata_ld    = 1'b0;
    seen_busy_d = 1'b0;
    unique case (state_q)
      IDLE:    ferr_d = bad;
      WR_ADDR: begin
        ferr_d  = bad | tmo;
        addr_ld = good;
      end
      WR_DATA: begin
        ferr_d   = bad | tmo;
        wdata_ld = good;
        wr_en_d  = good;
      end
      RD_ADDR: begin
        ferr_d  = bad | tmo;
        addr_ld = good;
        rd_en_d = good;
      end
      RD_WAIT: begin
        ferr_d     = rx_valid;
        rdata_ld   = rf_rd_valid;
        tx_valid_d = rf_rd_valid & ~tx_busy;
      end
      TX_SEND: begin
        ferr_d     = rx_valid;
        tx_valid_d = ~tx_busy;
      end
      TX_WAIT: begin
        ferr_d      = rx_valid;
        seen_busy_d = seen_busy_q | tx_busy;
      end
      default: ;
    endcase
  end

  // Datapath registers and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      tx_data_q   <= '0;
      seen_busy_q <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      tx_valid_q  <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      if (addr_ld)  addr_q  <= rx_data[ADDR_W-1:0];
      if (wdata_ld) wdata_q <= rx_data;
      if (rdata_ld) rdata_q <= rf_rd_data;
      // tx_data holds until the next transmission.
      if (tx_valid_d) tx_data_q <= (state_q == RD_WAIT) ? rf_rd_data : rdata_q;
      seen_busy_q <= seen_busy_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      tx_valid_q  <= tx_valid_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rf_addr    = addr_q;
  assign rf_wr_data = wdata_q;
  assign rf_wr_en   = wr_en_q;
  assign rf_rd_en   = rd_en_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: table of write/garbage frames plus hand-written
// read, reset and timeout sequences. Honours UART_CMD_TIMEOUT_EN if defined.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_par_err = 1'b0, rx_stp_err = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy = 1'b0;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en, rf_rd_en;
  logic [7:0] rf_rd_data = '0;
  logic       rf_rd_valid = 1'b0;
  logic       frame_err;

  uart_cmd_ctrl #(.ADDR_W(4), .WR_CMD(8'hAA), .RD_CMD(8'hBB), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int n_wr = 0, n_rd = 0, n_tx = 0, n_fe = 0, n_both = 0;
  int wr_cyc, rd_cyc, tx_cyc, fe_cyc;
  logic [3:0] wr_addr_s, rd_addr_s;
  logic [7:0] wr_data_s, tx_data_s;
  always @(negedge clk) begin
    if (rf_wr_en) begin n_wr++; wr_cyc = cyc; wr_addr_s = rf_addr; wr_data_s = rf_wr_data; end
    if (rf_rd_en) begin n_rd++; rd_cyc = cyc; rd_addr_s = rf_addr; end
    if (tx_valid) begin n_tx++; tx_cyc = cyc; tx_data_s = tx_data; end
    if (frame_err) begin n_fe++; fe_cyc = cyc; end
    if (rf_wr_en && rf_rd_en) n_both++;
  end

  int total = 0, bad = 0, last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle byte strobe; returns 1ns after the following negedge.
  task automatic send_byte(input logic [7:0] b, input logic par, input logic stp);
    @(negedge clk);
    rx_data = b; rx_par_err = par; rx_stp_err = stp; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
    last_cyc = cyc;
    #1;
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
    int w0, f0, lc;
    w0 = n_wr; f0 = n_fe;
    send_byte(8'hAA, 0, 0); send_byte(a, 0, 0); send_byte(d, 0, 0);
    lc = last_cyc;
    repeat (2) @(negedge clk);
    #1;
    chk("wrf_cnt", n_wr - w0, 1);
    chk("wrf_addr", wr_addr_s, a[3:0]);
    chk("wrf_data", wr_data_s, d);
    chk("wrf_lat", wr_cyc - lc, 0);
    chk("wrf_ferr", n_fe - f0, 0);
  endtask

  typedef struct {
    logic [2:0][7:0] b;
    logic [2:0]      par;
    logic [2:0]      stp;
    int              nb;
    int              exp_wr;
    logic [3:0]      exp_addr;
    logic [7:0]      exp_data;
    int              exp_fe;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int w0, f0, t0, r0, lc, m;

    vecs[0]  = '{{8'h5C, 8'h03, 8'hAA}, 3'b000, 3'b000, 3, 1, 4'h3, 8'h5C, 0};
    vecs[1]  = '{{8'h00, 8'h03, 8'hAA}, 3'b010, 3'b000, 2, 0, 4'h0, 8'h00, 1};
    vecs[2]  = '{{8'hFF, 8'h01, 8'hAA}, 3'b000, 3'b000, 3, 1, 4'h1, 8'hFF, 0};
    vecs[3]  = '{{8'h00, 8'h00, 8'h55}, 3'b000, 3'b000, 1, 0, 4'h0, 8'h00, 0};
    vecs[4]  = '{{8'h10, 8'h02, 8'hAA}, 3'b000, 3'b000, 3, 1, 4'h2, 8'h10, 0};
    vecs[5]  = '{{8'h3C, 8'hF7, 8'hAA}, 3'b000, 3'b000, 3, 1, 4'h7, 8'h3C, 0};
    vecs[6]  = '{{8'h99, 8'h05, 8'hAA}, 3'b000, 3'b100, 3, 0, 4'h0, 8'h00, 1};
    vecs[7]  = '{{8'h00, 8'h00, 8'h12}, 3'b001, 3'b000, 1, 0, 4'h0, 8'h00, 1};
    vecs[8]  = '{{8'h00, 8'h06, 8'hAA}, 3'b000, 3'b010, 2, 0, 4'h0, 8'h00, 1};
    vecs[9]  = '{{8'h00, 8'h00, 8'hBB}, 3'b000, 3'b001, 1, 0, 4'h0, 8'h00, 1};
    vecs[10] = '{{8'h00, 8'h0F, 8'hAA}, 3'b000, 3'b000, 3, 1, 4'hF, 8'h00, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", {tx_data, tx_valid, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, frame_err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_outs", {tx_data, tx_valid, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, frame_err}, 0);

    // Frame table
    for (int i = 0; i < 11; i++) begin
      w0 = n_wr; f0 = n_fe;
      for (int j = 0; j < vecs[i].nb; j++)
        send_byte(vecs[i].b[j], vecs[i].par[j], vecs[i].stp[j]);
      lc = last_cyc;
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("v%0d_wr_cnt", i), n_wr - w0, vecs[i].exp_wr);
      chk($sformatf("v%0d_fe_cnt", i), n_fe - f0, vecs[i].exp_fe);
      if (vecs[i].exp_wr == 1) begin
        chk($sformatf("v%0d_addr", i), wr_addr_s, vecs[i].exp_addr);
        chk($sformatf("v%0d_data", i), wr_data_s, vecs[i].exp_data);
        chk($sformatf("v%0d_lat", i), wr_cyc - lc, 0);
      end
    end

    // Read, rf_rd_valid two cycles after rf_rd_en, TX idle
    r0 = n_rd; t0 = n_tx; f0 = n_fe;
    send_byte(8'hBB, 0, 0); send_byte(8'h07, 0, 0);
    lc = last_cyc;
    chk("r1_rd_cnt", n_rd - r0, 1);
    chk("r1_rd_lat", rd_cyc - lc, 0);
    chk("r1_rd_addr", rd_addr_s, 4'h7);
    @(negedge clk); @(negedge clk);
    rf_rd_valid = 1'b1; rf_rd_data = 8'hE1;
    @(negedge clk);
    rf_rd_valid = 1'b0; rf_rd_data = 8'h00;
    m = cyc;
    #1;
    chk("r1_tx_cnt", n_tx - t0, 1);
    chk("r1_tx_lat", tx_cyc - m, 0);
    chk("r1_tx_data", tx_data_s, 8'hE1);
    tx_busy = 1'b1;
    repeat (4) @(negedge clk);
    tx_busy = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("r1_tx_once", n_tx - t0, 1);
    chk("r1_tx_hold", tx_data, 8'hE1);
    chk("r1_ferr", n_fe - f0, 0);
    wr_frame(8'h08, 8'h66);

    // Read with TX busy for 20 cycles after rf_rd_valid
    t0 = n_tx;
    tx_busy = 1'b1;
    send_byte(8'hBB, 0, 0); send_byte(8'h02, 0, 0);
    rf_rd_valid = 1'b1; rf_rd_data = 8'h3C;
    @(negedge clk);
    rf_rd_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("r2_no_tx_busy", n_tx - t0, 0);
    tx_busy = 1'b0;
    m = cyc;
    @(negedge clk);
    #1;
    chk("r2_tx_cnt", n_tx - t0, 1);
    chk("r2_tx_lat", tx_cyc - m, 1);
    chk("r2_tx_data", tx_data_s, 8'h3C);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("r2_tx_once", n_tx - t0, 1);
    wr_frame(8'h09, 8'hA5);

    // Extra byte during RD_WAIT: frame_err, read still answered
    t0 = n_tx; f0 = n_fe;
    send_byte(8'hBB, 0, 0); send_byte(8'h05, 0, 0);
    send_byte(8'h42, 0, 0);
    @(negedge clk);
    #1;
    chk("r3_ferr", n_fe - f0, 1);
    @(negedge clk);
    rf_rd_valid = 1'b1; rf_rd_data = 8'h5A;
    @(negedge clk);
    rf_rd_valid = 1'b0;
    #1;
    chk("r3_tx_cnt", n_tx - t0, 1);
    chk("r3_tx_data", tx_data_s, 8'h5A);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    wr_frame(8'h0A, 8'h11);

    // Reset mid-frame discards the frame
    w0 = n_wr; f0 = n_fe;
    send_byte(8'hAA, 0, 0); send_byte(8'h03, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {tx_data, tx_valid, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, frame_err}, 0);
    rst_n = 1'b1;
    send_byte(8'h5C, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_wr", n_wr - w0, 0);
    chk("midrst_no_fe", n_fe - f0, 0);

    // Silence after the address byte
    w0 = n_wr; f0 = n_fe;
    send_byte(8'hAA, 0, 0); send_byte(8'h04, 0, 0);
    lc = last_cyc;
    repeat (30) @(negedge clk);
    #1;
`ifdef UART_CMD_TIMEOUT_EN
    chk("tmo_fe_cnt", n_fe - f0, 1);
    chk("tmo_fe_lat", fe_cyc - lc, 16);
    send_byte(8'h77, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("tmo_no_wr", n_wr - w0, 0);
`else
    chk("notmo_fe", n_fe - f0, 0);
    send_byte(8'h77, 0, 0);
    lc = last_cyc;
    repeat (2) @(negedge clk);
    #1;
    chk("notmo_wr_cnt", n_wr - w0, 1);
    chk("notmo_addr", wr_addr_s, 4'h4);
    chk("notmo_data", wr_data_s, 8'h77);
    chk("notmo_lat", wr_cyc - lc, 0);
`endif

    chk("wr_rd_overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
System-side command controller that sits on the parallel side of the UART block. It consumes received bytes (RX_OUT_P/RX_OUT_V plus error flags) and parses them as write or read command frames into a register-file port. For read commands it returns the read byte through the UART TX parallel input (TX_IN_P/TX_IN_V), throttled by the TX busy flag.

Parameters:
ADDR_W, 4, register-file address width; taken from the low ADDR_W bits of the address byte.
WR_CMD, 8'hAA, command byte opening a write frame.
RD_CMD, 8'hBB, command byte opening a read frame.
TIMEOUT_CYC, 1024, inter-byte timeout in clk cycles; used only with UART_CMD_TIMEOUT_EN.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
rx_data  input  8  received byte (UART RX_OUT_P).
rx_valid  input  1  one-cycle strobe: rx_data is valid.
rx_par_err  input  1  parity error for the current byte; qualified by rx_valid.
rx_stp_err  input  1  stop error for the current byte; qualified by rx_valid.
tx_data  output  8  byte to transmit (UART TX_IN_P).
tx_valid  output  1  one-cycle transmit request (UART TX_IN_V).
tx_busy  input  1  UART TX busy (TX_OUT_V); already in clk domain.
rf_addr  output  ADDR_W  register-file address.
rf_wr_data  output  8  register-file write data.
rf_wr_en  output  1  one-cycle write strobe.
rf_rd_en  output  1  one-cycle read strobe.
rf_rd_data  input  8  register-file read data.
rf_rd_valid  input  1  read data valid strobe.
frame_err  output  1  one-cycle pulse: frame aborted.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal addr/data registers 0. Reset mid-frame discards the frame and issues no strobes.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, TX_WAIT.
- Good byte: rx_valid=1, rx_par_err=0, rx_stp_err=0. Bad byte: rx_valid=1 with either error flag set.
- IDLE: good byte == WR_CMD -> WR_ADDR; == RD_CMD -> RD_ADDR; any other good byte is discarded with no pulse and the state stays IDLE. Bad byte -> frame_err, stay IDLE.
- WR_ADDR: good byte is latched as the address -> WR_DATA.
- WR_DATA: good byte -> in the next cycle rf_wr_en=1 for exactly 1 cycle with rf_addr/rf_wr_data valid; then IDLE.
- RD_ADDR: good byte -> in the next cycle rf_rd_en=1 for 1 cycle with rf_addr valid -> RD_WAIT.
- RD_WAIT: on rf_rd_valid, latch rf_rd_data -> TX_SEND. rf_rd_valid may arrive in the same cycle as rf_rd_en+1 or later; wait indefinitely.
- TX_SEND: when tx_busy=0, drive tx_valid=1 for 1 cycle with tx_data=latched byte -> TX_WAIT. tx_data holds its value until the next transmission.
- TX_WAIT: wait for tx_busy=1 followed by tx_busy=0 -> IDLE. tx_valid is never re-asserted while in TX_WAIT.
- Bad byte in WR_ADDR, WR_DATA, or RD_ADDR: frame_err pulse, no strobe, -> IDLE.
- Any rx_valid in RD_WAIT, TX_SEND, or TX_WAIT: byte dropped, frame_err pulse, the in-progress read completes normally.
- rf_wr_en and rf_rd_en are never asserted together. rf_addr = addr_byte[ADDR_W-1:0].
- Latency:
  - write: last byte strobe -> rf_wr_en, 1 cycle.
  - read: address strobe -> rf_rd_en, 1 cycle; rf_rd_valid -> tx_valid, 1 cycle when tx_busy=0.

Optional Feature:
UART_CMD_TIMEOUT_EN:
- Defined: a counter runs in WR_ADDR, WR_DATA, and RD_ADDR, cleared on entry and on every rx_valid. Reaching TIMEOUT_CYC cycles without rx_valid causes a frame_err pulse and -> IDLE with no strobes.
- Undefined: no counter; these states wait forever. TIMEOUT_CYC is unused.

Test Plan:
- Bytes AA,03,5C (good) -> one rf_wr_en pulse, rf_addr=3, rf_wr_data=8'h5C, 1 cycle after the 5C strobe; frame_err stays 0.
- Bytes BB,07; rf_rd_valid with rf_rd_data=8'hE1 two cycles after rf_rd_en; tx_busy=0 -> tx_valid pulse with tx_data=E1 exactly once; after a busy high/low cycle, back in IDLE.
- Read with tx_busy=1 held 20 cycles after rf_rd_valid -> tx_valid asserted only in the first cycle after tx_busy falls.
- AA, then 03 with rx_par_err=1 -> frame_err pulse, no rf_wr_en; then a fresh AA,01,FF frame writes addr 1 = FF.
- Byte 55, then AA,02,10 -> 55 ignored without frame_err; write of addr 2 = 10 occurs. An extra byte during RD_WAIT -> frame_err, read response still sent.
- With UART_CMD_TIMEOUT_EN, TIMEOUT_CYC=16: AA,04 then silence -> frame_err after 16 cycles and no rf_wr_en. Without the macro, the same stimulus gives no frame_err and a later 77 byte completes the write.
